// File: rtl/cv32e40x_pkg.sv
// Shared types and helpers for the XIF result arbiter: default-width result entry,
// exception-code width and the round-robin grant search.
package cv32e40x_pkg;

  localparam int XIF_EXCCODE_W = 6;

  typedef struct packed {
    logic [3:0]               id;
    logic [31:0]              data;
    logic [4:0]               rd;
    logic [0:0]               we;
    logic                     exc;
    logic [XIF_EXCCODE_W-1:0] exccode;
  } xif_result_entry_t;

  // First requester at or after ptr, wrapping modulo n (n <= 32); ptr when nothing requests.
  function automatic int unsigned rr_next(input int unsigned ptr, input logic [31:0] req,
                                          input int unsigned n);
    int unsigned idx;
    logic        found;
    rr_next = ptr;
    found   = 1'b0;
    for (int unsigned k = 0; k < 32; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && req[idx[4:0]]) begin
        rr_next = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/cv32e40x_xif_result_arbiter_if.sv
// Bundle of the per-channel coprocessor result inputs and the merged core result port.
interface cv32e40x_xif_result_arbiter_if
  import cv32e40x_pkg::*;
#(
  parameter int X_NUM_CH    = 2,
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32
);
  localparam int CH_W = (X_NUM_CH > 1) ? $clog2(X_NUM_CH) : 1;
  localparam int WE_W = X_RFW_WIDTH / 32;

  logic [X_NUM_CH-1:0]                        ch_valid_i;
  logic [X_NUM_CH-1:0]                        ch_ready_o;
  logic [X_NUM_CH-1:0][X_ID_WIDTH-1:0]        ch_id_i;
  logic [X_NUM_CH-1:0][X_RFW_WIDTH-1:0]       ch_data_i;
  logic [X_NUM_CH-1:0][4:0]                   ch_rd_i;
  logic [X_NUM_CH-1:0][WE_W-1:0]              ch_we_i;
  logic [X_NUM_CH-1:0]                        ch_exc_i;
  logic [X_NUM_CH-1:0][XIF_EXCCODE_W-1:0]     ch_exccode_i;

  logic                     result_valid_o;
  logic                     result_ready_i;
  logic [X_ID_WIDTH-1:0]    result_id_o;
  logic [X_RFW_WIDTH-1:0]   result_data_o;
  logic [4:0]               result_rd_o;
  logic [WE_W-1:0]          result_we_o;
  logic                     result_exc_o;
  logic [XIF_EXCCODE_W-1:0] result_exccode_o;
  logic [CH_W-1:0]          result_ch_o;

  modport master (
    output ch_valid_i, ch_id_i, ch_data_i, ch_rd_i, ch_we_i, ch_exc_i, ch_exccode_i, result_ready_i,
    input  ch_ready_o, result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
           result_exc_o, result_exccode_o, result_ch_o
  );

  modport slave (
    input  ch_valid_i, ch_id_i, ch_data_i, ch_rd_i, ch_we_i, ch_exc_i, ch_exccode_i, result_ready_i,
    output ch_ready_o, result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o,
           result_exc_o, result_exccode_o, result_ch_o
  );
endinterface

// File: rtl/cv32e40x_xif_result_fifo.sv
// Per-channel result FIFO; pointers carry one extra wrap bit to tell full from empty.
module cv32e40x_xif_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]                  wptr_q, rptr_q;
  logic [DEPTH-1:0][WIDTH-1:0]  mem_q;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_q  <= '0;
    end else if (flush) begin
      // flush drops any same-cycle push
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) begin
        mem_q[wptr_q[AW-1:0]] <= wdata;
        wptr_q                <= wptr_q + (AW+1)'(1);
      end
      if (pop && !empty) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/cv32e40x_xif_result_arbiter.sv
// Merges X_NUM_CH coprocessor result channels into one core result port: per-channel FIFOs,
// locked round-robin grant. Define XIF_RESULT_EXC_PRIO_EN to let excepting heads bypass round-robin.
module cv32e40x_xif_result_arbiter
  import cv32e40x_pkg::*;
#(
  parameter int X_NUM_CH    = 2,
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush_i,
  cv32e40x_xif_result_arbiter_if.slave   xif
);
  localparam int CH_W  = (X_NUM_CH > 1) ? $clog2(X_NUM_CH) : 1;
  localparam int WE_W  = X_RFW_WIDTH / 32;
  localparam int ENT_W = X_ID_WIDTH + X_RFW_WIDTH + 5 + WE_W + 1 + XIF_EXCCODE_W;
  localparam int EXC_B = XIF_EXCCODE_W;

  logic [X_NUM_CH-1:0]            full, empty, push, pop;
  logic [X_NUM_CH-1:0][ENT_W-1:0] wdata, rdata;
  logic                           valid, fire;
  logic [CH_W-1:0]                ptr_q, ptr_d, gnt_q, gnt, arb_gnt;
  logic                           lock_q, prio_q, prio, arb_prio;

  for (genvar i = 0; i < X_NUM_CH; i++) begin : g_ch
    assign push[i]  = xif.ch_valid_i[i] & ~full[i];
    assign pop[i]   = fire & (gnt == CH_W'(i));
    assign wdata[i] = {xif.ch_id_i[i], xif.ch_data_i[i], xif.ch_rd_i[i], xif.ch_we_i[i],
                       xif.ch_exc_i[i], xif.ch_exccode_i[i]};

    cv32e40x_xif_result_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENT_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush_i),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (wdata[i]),
      .rdata (rdata[i]),
      .full  (full[i]),
      .empty (empty[i])
    );
  end

  assign xif.ch_ready_o = ~full;
  assign valid          = ~&empty;
  assign fire           = valid & xif.result_ready_i;

  always_comb begin
    arb_gnt  = CH_W'(rr_next(32'(ptr_q), 32'(~empty), X_NUM_CH));
    arb_prio = 1'b0;
`ifdef XIF_RESULT_EXC_PRIO_EN
    // descending scan so the lowest excepting index is the one left standing
    for (int i = X_NUM_CH-1; i >= 0; i--) begin
      if (!empty[i] && rdata[i][EXC_B]) begin
        arb_gnt  = CH_W'(i);
        arb_prio = 1'b1;
      end
    end
`endif
  end

  // a stalled result keeps the grant it was presented with
  assign gnt  = lock_q ? gnt_q  : arb_gnt;
  assign prio = lock_q ? prio_q : arb_prio;

  always_comb begin
    ptr_d = ptr_q;
    if (fire && !prio && !flush_i)
      ptr_d = (gnt == CH_W'(X_NUM_CH-1)) ? '0 : gnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      prio_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt;
      prio_q <= prio;
      lock_q <= valid & ~xif.result_ready_i & ~flush_i;
    end
  end

  assign xif.result_valid_o = valid;
  assign {xif.result_id_o, xif.result_data_o, xif.result_rd_o, xif.result_we_o,
          xif.result_exc_o, xif.result_exccode_o} = valid ? rdata[gnt] : '0;
  assign xif.result_ch_o    = valid ? gnt : '0;
endmodule

// File: tb/tb_cv32e40x_xif_result_arbiter.sv
// Scoreboard bench for the XIF result arbiter: directed pushes queue hand-ordered expected
// results, a negedge monitor checks every accepted result against the queue head.
module tb_cv32e40x_xif_result_arbiter;
  import cv32e40x_pkg::*;

  typedef struct packed {
    xif_result_entry_t e;
    logic              ch;
  } exp_t;

  logic clk, rst_n, flush;
  int   n_tests, n_fail;
  exp_t sb[$];
  exp_t got, want;

  cv32e40x_xif_result_arbiter_if #(.X_NUM_CH(2), .X_ID_WIDTH(4), .X_RFW_WIDTH(32)) xif();

  cv32e40x_xif_result_arbiter #(.X_NUM_CH(2), .X_ID_WIDTH(4), .X_RFW_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .xif     (xif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic xif_result_entry_t mk(input logic [3:0] id, input logic exc, input logic [5:0] code);
    xif_result_entry_t r;
    r.id      = id;
    r.data    = 32'hC0DE_0000 + 32'(id) * 32'h111;
    r.rd      = 5'(id) + 5'd3;
    r.we      = id[0];
    r.exc     = exc;
    r.exccode = code;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic setch(input int ch, input logic [3:0] id, input logic exc, input logic [5:0] code);
    xif_result_entry_t r;
    r = mk(id, exc, code);
    xif.ch_valid_i[ch]   = 1'b1;
    xif.ch_id_i[ch]      = r.id;
    xif.ch_data_i[ch]    = r.data;
    xif.ch_rd_i[ch]      = r.rd;
    xif.ch_we_i[ch]      = r.we;
    xif.ch_exc_i[ch]     = r.exc;
    xif.ch_exccode_i[ch] = r.exccode;
  endtask

  task automatic expect_e(input int ch, input logic [3:0] id, input logic exc, input logic [5:0] code);
    exp_t x;
    x.e  = mk(id, exc, code);
    x.ch = 1'(ch);
    sb.push_back(x);
  endtask

  task automatic idle();
    xif.ch_valid_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    chk({name, "_drain"}, 64'(sb.size()), 64'd0);
    tick();
    chk({name, "_idle"}, 64'(xif.result_valid_o), 64'd0);
  endtask

  // monitor: every accepted result must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && xif.result_valid_o && xif.result_ready_i) begin
      got.e = {xif.result_id_o, xif.result_data_o, xif.result_rd_o, xif.result_we_o,
               xif.result_exc_o, xif.result_exccode_o};
      got.ch = xif.result_ch_o;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: got id=%0d ch=%0d, required no result", got.e.id, got.ch);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          n_fail++;
          $display("FAIL result: got id=%0d ch=%0d data=%h rd=%0d we=%b exc=%b code=%0d, required id=%0d ch=%0d data=%h rd=%0d we=%b exc=%b code=%0d",
                   got.e.id, got.ch, got.e.data, got.e.rd, got.e.we, got.e.exc, got.e.exccode,
                   want.e.id, want.ch, want.e.data, want.e.rd, want.e.we, want.e.exc, want.e.exccode);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    xif.ch_valid_i = '0; xif.ch_id_i = '0; xif.ch_data_i = '0; xif.ch_rd_i = '0;
    xif.ch_we_i = '0; xif.ch_exc_i = '0; xif.ch_exccode_i = '0;
    xif.result_ready_i = 1'b0;

    // reset state
    #12;
    chk("rst_valid", 64'(xif.result_valid_o), 64'd0);
    chk("rst_ready", 64'(xif.ch_ready_o), 64'd3);
    chk("rst_id",    64'(xif.result_id_o), 64'd0);
    chk("rst_data",  64'(xif.result_data_o), 64'd0);
    chk("rst_ch",    64'(xif.result_ch_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: simultaneous pushes drain ch0 then ch1
    xif.result_ready_i = 1'b1;
    setch(0, 4'd3, 1'b0, 6'd0); setch(1, 4'd5, 1'b0, 6'd0);
    expect_e(0, 4'd3, 1'b0, 6'd0); expect_e(1, 4'd5, 1'b0, 6'd0);
    tick(); idle();
    @(negedge clk);
    chk("t1_first_visible", 64'(xif.result_valid_o), 64'd1);
    drain("t1");

    // 2: stalled output stays locked while ch1 fills
    xif.result_ready_i = 1'b0;
    setch(0, 4'd1, 1'b0, 6'd0); expect_e(0, 4'd1, 1'b0, 6'd0);
    tick(); idle();
    setch(1, 4'd2, 1'b0, 6'd0); expect_e(1, 4'd2, 1'b0, 6'd0);
    tick(); idle();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t2_lock_valid", 64'(xif.result_valid_o), 64'd1);
      chk("t2_lock_id",    64'(xif.result_id_o), 64'd1);
      chk("t2_lock_ch",    64'(xif.result_ch_o), 64'd0);
    end
    @(posedge clk); #1;
    xif.result_ready_i = 1'b1;
    drain("t2");

    // 3: full FIFO back-pressure, third push held, order kept
    xif.result_ready_i = 1'b0;
    setch(0, 4'd6, 1'b0, 6'd0); expect_e(0, 4'd6, 1'b0, 6'd0); tick();
    setch(0, 4'd7, 1'b0, 6'd0); expect_e(0, 4'd7, 1'b0, 6'd0); tick();
    setch(0, 4'd8, 1'b0, 6'd0); expect_e(0, 4'd8, 1'b0, 6'd0);
    @(negedge clk);
    chk("t3_full_ready", 64'(xif.ch_ready_o), 64'd2);
    tick();
    @(negedge clk);
    chk("t3_held_ready", 64'(xif.ch_ready_o), 64'd2);
    chk("t3_held_id",    64'(xif.result_id_o), 64'd6);
    @(posedge clk); #1;
    xif.result_ready_i = 1'b1;
    tick();
    chk("t3_ready_after_pop", 64'(xif.ch_ready_o[0]), 64'd1);
    tick(); idle();
    drain("t3");

    // 4: flush with three buffered entries and a same-cycle ch1 push
    xif.result_ready_i = 1'b0;
    setch(0, 4'd9, 1'b0, 6'd0); setch(1, 4'd10, 1'b0, 6'd0); tick(); idle();
    setch(0, 4'd11, 1'b0, 6'd0); tick(); idle();
    @(negedge clk);
    chk("t4_pre_valid", 64'(xif.result_valid_o), 64'd1);
    chk("t4_pre_ready", 64'(xif.ch_ready_o), 64'd2);
    @(posedge clk); #1;
    flush = 1'b1;
    setch(1, 4'd12, 1'b0, 6'd0);
    tick();
    flush = 1'b0; idle();
    @(negedge clk);
    chk("t4_flush_valid", 64'(xif.result_valid_o), 64'd0);
    chk("t4_flush_ready", 64'(xif.ch_ready_o), 64'd3);
    @(posedge clk); #1;
    xif.result_ready_i = 1'b1;
    tick(); tick(); tick();
    chk("t4_stays_empty", 64'(xif.result_valid_o), 64'd0);

    // 5: async reset mid-stream; pointer first moved to 1
    setch(0, 4'd14, 1'b0, 6'd0); expect_e(0, 4'd14, 1'b0, 6'd0); tick(); idle();
    drain("t5_pre");
    xif.result_ready_i = 1'b0;
    setch(1, 4'd13, 1'b0, 6'd0); tick(); idle();
    @(negedge clk);
    chk("t5_pre_valid", 64'(xif.result_valid_o), 64'd1);
    #2; rst_n = 1'b0; #1;
    chk("t5_rst_valid", 64'(xif.result_valid_o), 64'd0);
    chk("t5_rst_id",    64'(xif.result_id_o), 64'd0);
    chk("t5_rst_ready", 64'(xif.ch_ready_o), 64'd3);
    @(negedge clk); #2; rst_n = 1'b1;
    tick();
    xif.result_ready_i = 1'b1;
    setch(0, 4'd4, 1'b0, 6'd0); setch(1, 4'd15, 1'b0, 6'd0);
    expect_e(0, 4'd4, 1'b0, 6'd0); expect_e(1, 4'd15, 1'b0, 6'd0);
    tick(); idle();
    drain("t5");

    // 6: exception heads against round-robin, pointer at 0
    xif.result_ready_i = 1'b0;
    setch(0, 4'd6, 1'b0, 6'd0); setch(1, 4'd7, 1'b1, 6'd2);
`ifdef XIF_RESULT_EXC_PRIO_EN
    expect_e(1, 4'd7, 1'b1, 6'd2); expect_e(0, 4'd6, 1'b0, 6'd0);
`else
    expect_e(0, 4'd6, 1'b0, 6'd0); expect_e(1, 4'd7, 1'b1, 6'd2);
`endif
    tick(); idle(); tick();
    xif.result_ready_i = 1'b1;
    drain("t6");

`ifdef XIF_RESULT_EXC_PRIO_EN
    // pointer is 1 here; an exception grant of ch1 must leave it at 1
    xif.result_ready_i = 1'b0;
    setch(0, 4'd10, 1'b0, 6'd0); setch(1, 4'd11, 1'b1, 6'd5); tick(); idle();
    setch(1, 4'd12, 1'b0, 6'd0); tick(); idle();
    expect_e(1, 4'd11, 1'b1, 6'd5); expect_e(1, 4'd12, 1'b0, 6'd0); expect_e(0, 4'd10, 1'b0, 6'd0);
    xif.result_ready_i = 1'b1;
    drain("t6b");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
